// File: rtl/add_seq_ctrl.sv
// Sequencing controller for an external registered two-operand adder:
// accumulates NUM_TERMS unsigned terms and presents the sum on a valid/ready port.
module add_seq_ctrl #(
    parameter int NUM_TERMS  = 4,
    parameter int BIT_INPUT  = 21,
    parameter int BIT_OUTPUT = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIT_INPUT-1:0]    in_data,
    output logic [2*BIT_OUTPUT-1:0] add_in,
    input  logic [BIT_OUTPUT-1:0]   add_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIT_OUTPUT-1:0]   out_data,
    output logic                    busy
);

    localparam int CW = $clog2(NUM_TERMS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_TERMS);

    typedef enum logic [1:0] {
        ACCEPT,
        WAIT,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_OUTPUT-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_in    = '0;
        case (state_q)
            ACCEPT: begin
                in_ready = !clear;
                // The adder is only issued on a real handshake, never while aborting.
                if (in_valid && !clear) begin
                    add_in  = {BIT_OUTPUT'(in_data), acc_q};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                acc_d   = add_out;
                state_d = (cnt_q == CNT_LAST) ? OUT : ACCEPT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
        if (clear) begin
            state_d = ACCEPT;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    assign out_data = acc_q;
    assign busy     = (state_q != ACCEPT) || (cnt_q != '0);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: two instances (28-bit and 22-bit results) share stimulus;
// a cycle-timeline model of the accumulation is checked every cycle, plus literal results.
module tb_add_seq_ctrl;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [20:0] in_data;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [55:0] add_in_a;
    logic [27:0] add_out_a = '0;
    logic [27:0] out_data_a;

    logic        in_ready_b, out_valid_b, busy_b;
    logic [43:0] add_in_b;
    logic [21:0] add_out_b = '0;
    logic [21:0] out_data_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    add_seq_ctrl dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .add_in(add_in_a), .add_out(add_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .busy(busy_a)
    );

    add_seq_ctrl #(.NUM_TERMS(NT), .BIT_INPUT(21), .BIT_OUTPUT(22)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .add_in(add_in_b), .add_out(add_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    // External registered adders
    always @(posedge clk) begin
        add_out_a <= add_in_a[27:0] + add_in_a[55:28];
        add_out_b <= add_in_b[21:0] + add_in_b[43:22];
        cyc       <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: terms accepted this job, sum of terms whose adder result has landed,
    // and the cycle of the latest accept (its result lands one cycle later).
    bit          m_live = 1'b0;
    int          m_n    = 0;
    int          m_last = -10;
    longint      m_sum  = 0;
    longint      m_term = 0;

    int          hs[$];
    int          res_cyc[$];
    logic [63:0] res_a[$];
    logic [63:0] res_b[$];

    always @(negedge clk) begin
        bit          waiting, outv, rdy, acc_hs;
        logic [63:0] acc_a, acc_b;
        waiting = 1'b0; outv = 1'b0; rdy = 1'b0; acc_hs = 1'b0;
        acc_a   = '0;   acc_b = '0;
        if (m_live) begin
            waiting = (cyc == m_last + 1);
            outv    = (m_n == NT) && !waiting;
            rdy     = !clear && !waiting && !outv;
            acc_hs  = rdy && in_valid;
            acc_a   = 64'(m_sum) & ((64'd1 << 28) - 1);
            acc_b   = 64'(m_sum) & ((64'd1 << 22) - 1);
            check("a_in_ready",  64'(in_ready_a),  64'(rdy));
            check("a_out_valid", 64'(out_valid_a), 64'(outv));
            check("a_busy",      64'(busy_a),      64'(m_n != 0));
            check("a_out_data",  64'(out_data_a),  acc_a);
            check("a_add_in",    64'(add_in_a),    acc_hs ? ((64'(in_data) << 28) | acc_a) : 64'd0);
            check("b_in_ready",  64'(in_ready_b),  64'(rdy));
            check("b_out_valid", 64'(out_valid_b), 64'(outv));
            check("b_busy",      64'(busy_b),      64'(m_n != 0));
            check("b_out_data",  64'(out_data_b),  acc_b);
            check("b_add_in",    64'(add_in_b),    acc_hs ? ((64'(in_data) << 22) | acc_b) : 64'd0);
            if (in_ready_a && in_valid) hs.push_back(cyc);
            if (out_valid_a && out_ready) begin
                res_cyc.push_back(cyc);
                res_a.push_back(64'(out_data_a));
            end
            if (out_valid_b && out_ready) res_b.push_back(64'(out_data_b));
        end
        if (rst || (m_live && clear)) begin
            m_live = 1'b1; m_n = 0; m_sum = 0; m_last = -10;
        end else if (m_live) begin
            if (waiting) m_sum += m_term;
            if (acc_hs) begin
                m_n++;
                m_term = longint'(in_data);
                m_last = cyc;
            end
            if (outv && out_ready) begin
                m_n = 0; m_sum = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [20:0] d, input bit drop);
        bit got = 1'b0;
        int k   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!got && k < 50) begin
            @(negedge clk);
            got = in_ready_a;
            step();
            k++;
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (res_a.size() < n && k < 100) begin
            step();
            k++;
        end
        if (res_a.size() < n) check("result_timeout", 64'(res_a.size()), 64'(n));
    endtask

    task automatic wait_out();
        int k = 0;
        @(negedge clk);
        while (!out_valid_a && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid_a) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready_a),  64'd1);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_out_data",  64'(out_data_a),  64'd0);
        check("rst_add_in",    64'(add_in_a),    64'd0);
        check("rst_busy",      64'(busy_a),      64'd0);
        step();

        // Terms 1..4 then 4 x max, in_valid held high, out_ready high
        out_ready = 1'b1;
        base = hs.size();
        send(21'd1, 1'b0); send(21'd2, 1'b0); send(21'd3, 1'b0); send(21'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(21'h1FFFFF, i == 3);
        wait_res(2);
        if (hs.size() >= base + 5 && res_cyc.size() >= 1) begin
            check("hs_gap_1",    64'(hs[base+1] - hs[base]), 64'd2);
            check("hs_gap_3",    64'(hs[base+3] - hs[base]), 64'd6);
            check("out_latency", 64'(res_cyc[0] - hs[base]), 64'd8);
            check("next_accept", 64'(hs[base+4] - hs[base]), 64'd9);
        end else check("hs_log_size", 64'(hs.size()), 64'(base + 5));
        if (res_a.size() >= 2 && res_b.size() >= 2) begin
            check("sum_1234_a", res_a[0], 64'd10);
            check("sum_1234_b", res_b[0], 64'd10);
            check("sum_max_a",  res_a[1], 64'h7FFFFC);
            check("sum_max_b",  res_b[1], 64'h3FFFFC);
        end else check("res_log_size", 64'(res_b.size()), 64'd2);
        repeat (2) step();

        // Output backpressure
        out_ready = 1'b0;
        send(21'd1, 1'b0); send(21'd2, 1'b0); send(21'd3, 1'b0); send(21'd4, 1'b1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_data", 64'(out_data_a), 64'd10);
            check("bp_in_ready", 64'(in_ready_a), 64'd0);
            step();
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("release_in_ready", 64'(in_ready_a), 64'd1);
        check("release_acc",      64'(out_data_a), 64'd0);
        step();

        // Input gaps: 5,_,_,7,_,9,11
        r = res_a.size();
        send(21'd5, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("gap_busy", 64'(busy_a), 64'd1);
            step();
        end
        send(21'd7, 1'b1);
        step();
        send(21'd9, 1'b0); send(21'd11, 1'b1);
        wait_res(r + 1);
        if (res_a.size() > r) check("sum_gaps", res_a[r], 64'd32);
        repeat (2) step();

        // clear in the WAIT after the second term, then clear against in_valid
        send(21'd100, 1'b0); send(21'd200, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        check("adder_300", 64'(add_out_a), 64'd300);
        step();
        in_valid = 1'b1; in_data = 21'd55;
        @(negedge clk);
        check("clear_in_ready", 64'(in_ready_a), 64'd0);
        check("clear_add_in",   64'(add_in_a),   64'd0);
        step();
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clear_acc",  64'(out_data_a), 64'd0);
        check("clear_busy", 64'(busy_a),     64'd0);
        step();
        r = res_a.size();
        for (int i = 0; i < 4; i++) send(21'd1, i == 3);
        wait_res(r + 1);
        if (res_a.size() > r) check("sum_after_clear", res_a[r], 64'd4);
        repeat (2) step();

        // rst while a result is held in OUT
        out_ready = 1'b0;
        send(21'd1, 1'b0); send(21'd2, 1'b0); send(21'd3, 1'b0); send(21'd4, 1'b1);
        wait_out();
        check("held_before_rst", 64'(out_data_a), 64'd10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_out_valid", 64'(out_valid_a), 64'd0);
        check("postrst_out_data",  64'(out_data_a),  64'd0);
        check("postrst_in_ready",  64'(in_ready_a),  64'd1);
        step();
        out_ready = 1'b1;
        r = res_a.size();
        for (int i = 0; i < 4; i++) send(21'd2, i == 3);
        wait_res(r + 1);
        if (res_a.size() > r) check("sum_after_rst", res_a[r], 64'd8);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
